// File: rtl/wb_mem_bridge.sv
// rtl/wb_mem_bridge.sv - Wishbone slave to req/gnt/rvalid memory-port bridge (optional WBMEM_TIMEOUT_EN)
module wb_mem_bridge #(
  parameter int          MEM_AW      = 22,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [31:0]       wb_adr,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel,
  input  logic              wb_we,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic [2:0]        wb_cti,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_space,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RWAIT, S_ACK} state_t;

  localparam logic [1:0] SP_DRAM  = 2'd0;
  localparam logic [1:0] SP_VRAM  = 2'd1;
  localparam logic [1:0] SP_ROM   = 2'd2;
  localparam logic [1:0] SP_NVRAM = 2'd3;

  state_t            state_q;
  logic              wb_ack_q;
  logic [31:0]       wb_dat_o_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [1:0]        mem_space_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic              bus_err_q;
  // Set when the CPU abandons the cycle while the backend is still busy
  logic              abort_q;

  logic [1:0]        space_d;
  logic              mapped_d;
  logic              start_d;
  logic              keep_ack_d;
  logic              unused_adr;

`ifdef WBMEM_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit_d;
  assign tmo_hit_d = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

  assign unused_adr = ^wb_adr[1:0];

  // Region decode of the live CPU address; only consumed in IDLE
  always_comb begin
    space_d  = SP_DRAM;
    mapped_d = 1'b0;
    if (wb_adr[31:21] == 11'h000) begin
      space_d  = SP_DRAM;
      mapped_d = 1'b1;
    end else if (wb_adr[31:20] == 12'h002) begin
      space_d  = SP_VRAM;
      mapped_d = 1'b1;
    end else if (wb_adr[31:20] == 12'h030) begin
      space_d  = SP_ROM;
      mapped_d = 1'b1;
    end else if (wb_adr[31:18] == 14'h00C5) begin
      space_d  = SP_NVRAM;
      mapped_d = 1'b1;
    end
  end

  // End-of-burst beats (cti=111) never open a new access
  assign start_d    = wb_cyc & wb_stb & (wb_cti != 3'b111);
  // An abandoned cycle still completes on the backend but must not ack
  assign keep_ack_d = wb_cyc & ~abort_q;

  // Bridge FSM with all outputs registered
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wb_ack_q    <= 1'b0;
      wb_dat_o_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_space_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      bus_err_q   <= 1'b0;
      abort_q     <= 1'b0;
`ifdef WBMEM_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      wb_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            mem_addr_q  <= wb_adr[MEM_AW+1:2];
            mem_wdata_q <= wb_dat_i;
            mem_we_q    <= wb_we;
            mem_space_q <= space_d;
            mem_be_q    <= (wb_we && space_d == SP_NVRAM) ? 4'b0001 : wb_sel;
            abort_q     <= 1'b0;
            if (!mapped_d) begin
              bus_err_q <= 1'b1;
              if (!wb_we) wb_dat_o_q <= ERR_DATA;
              state_q   <= S_ACK;
              wb_ack_q  <= 1'b1;
            end else if (wb_we && (space_d == SP_ROM ||
                                   (space_d == SP_NVRAM && !wb_sel[0]))) begin
              // Dropped write: acknowledge without touching the backend
              state_q  <= S_ACK;
              wb_ack_q <= 1'b1;
            end else begin
              state_q   <= S_REQ;
              mem_req_q <= 1'b1;
`ifdef WBMEM_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end

        S_REQ: begin
          if (!wb_cyc) abort_q <= 1'b1;
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              if (keep_ack_d) begin
                state_q  <= S_ACK;
                wb_ack_q <= 1'b1;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              state_q <= S_RWAIT;
`ifdef WBMEM_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
`ifdef WBMEM_TIMEOUT_EN
          else if (tmo_hit_d) begin
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (!mem_we_q) wb_dat_o_q <= ERR_DATA;
            if (keep_ack_d) begin
              state_q  <= S_ACK;
              wb_ack_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end

        S_RWAIT: begin
          if (!wb_cyc) abort_q <= 1'b1;
          if (mem_rvalid) begin
            // NVRAM is byte-wide: only lane 0 carries data
            wb_dat_o_q <= (mem_space_q == SP_NVRAM) ? {24'h0, mem_rdata[7:0]} : mem_rdata;
            if (keep_ack_d) begin
              state_q  <= S_ACK;
              wb_ack_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
`ifdef WBMEM_TIMEOUT_EN
          else if (tmo_hit_d) begin
            bus_err_q  <= 1'b1;
            wb_dat_o_q <= ERR_DATA;
            if (keep_ack_d) begin
              state_q  <= S_ACK;
              wb_ack_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end

        S_ACK: begin
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_ack    = wb_ack_q;
  assign wb_dat_o  = wb_dat_o_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_space = mem_space_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_wb_mem_bridge.sv
// tb/tb_wb_mem_bridge.sv - directed scoreboard bench for wb_mem_bridge
module tb_wb_mem_bridge;
  localparam int AW = 22;

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic [31:0]   wb_adr, wb_dat_i, wb_dat_o, mem_wdata, mem_rdata;
  logic [3:0]    wb_sel, mem_be;
  logic          wb_we, wb_cyc, wb_stb, wb_ack;
  logic [2:0]    wb_cti;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid, bus_err;
  logic [1:0]    mem_space;
  logic [AW-1:0] mem_addr;

  always #5 sys_clk = ~sys_clk;

  wb_mem_bridge #(.MEM_AW(AW), .TIMEOUT_CYC(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_cti(wb_cti),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_space(mem_space), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  int            n_pass = 0;
  int            n_total = 0;
  logic [31:0]   exp_q[$];
  int            ack_cyc, req_cnt, seen_req, seen_ack;
  logic          stable;
  logic [AW-1:0] f_addr;
  logic [1:0]    f_space;
  logic [3:0]    f_be;
  logic          f_we;
  logic [31:0]   f_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One CPU access with a backend that grants at cycle gnt_at and returns
  // read data rv_dly cycles after the grant; stb is cycle 0
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input int gnt_at, input int rv_dly, input logic [31:0] rdata);
    int rv_at;
    logic [31:0] exp;
    rv_at = -1;
    ack_cyc = -1;
    req_cnt = 0;
    stable = 1'b1;
    @(posedge sys_clk); #1;
    wb_adr = adr; wb_dat_i = dat; wb_sel = sel; wb_we = we; wb_cti = 3'b000;
    wb_cyc = 1'b1; wb_stb = 1'b1; mem_rdata = rdata;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      if (wb_ack) begin
        ack_cyc = c;
        break;
      end
      if (mem_req) begin
        if (req_cnt == 0) begin
          f_addr = mem_addr; f_space = mem_space; f_be = mem_be; f_we = mem_we; f_wdata = mem_wdata;
        end else if ({mem_addr, mem_space, mem_be, mem_we, mem_wdata} !==
                     {f_addr, f_space, f_be, f_we, f_wdata}) begin
          stable = 1'b0;
        end
        req_cnt++;
      end
      mem_gnt = mem_req && (c >= gnt_at);
      if (mem_gnt && !mem_we) rv_at = c + rv_dly;
      mem_rvalid = (c == rv_at);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!we) begin
      chk("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        chk("rdata", wb_dat_o, exp);
      end
    end
    @(negedge sys_clk);
    chk("ack_once", wb_ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; wb_adr = '0; wb_dat_i = '0; wb_sel = '0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ack", wb_ack, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_space", mem_space, 0);
    reset_n = 1'b1;

    // DRAM read, minimum latency
    exp_q.push_back(32'h12345678);
    xfer(32'h0000_0100, 32'h0, 4'hF, 1'b0, 1, 1, 32'h12345678);
    chk("dram_ack_cyc", ack_cyc, 3);
    chk("dram_addr", f_addr, 32'h40);
    chk("dram_space", f_space, 0);
    chk("dram_we", f_we, 0);
    chk("dram_req_cnt", req_cnt, 1);

    // VRAM write with grant held off
    xfer(32'h0020_0004, 32'hCAFEBABE, 4'b0011, 1'b1, 4, 1, 32'h0);
    chk("vram_req_cnt", req_cnt, 4);
    chk("vram_stable", stable, 1);
    chk("vram_be", f_be, 4'b0011);
    chk("vram_space", f_space, 1);
    chk("vram_wdata", f_wdata, 32'hCAFEBABE);
    chk("vram_we", f_we, 1);
    chk("vram_ack_cyc", ack_cyc, 5);

    // ROM write dropped, ROM read mapped
    xfer(32'h0300_0000, 32'h5555_AAAA, 4'hF, 1'b1, 1, 1, 32'h0);
    chk("romw_ack_cyc", ack_cyc, 1);
    chk("romw_req_cnt", req_cnt, 0);
    exp_q.push_back(32'h0BADF00D);
    xfer(32'h0300_0010, 32'h0, 4'hF, 1'b0, 1, 1, 32'h0BADF00D);
    chk("romr_space", f_space, 2);
    chk("romr_addr", f_addr, 32'h000004);
    chk("romr_ack_cyc", ack_cyc, 3);

    // NVRAM: write without lane 0 dropped, lane-0 write forced, byte read
    xfer(32'h0314_0003, 32'h1100_0000, 4'b1000, 1'b1, 1, 1, 32'h0);
    chk("nvw_drop_ack_cyc", ack_cyc, 1);
    chk("nvw_drop_req_cnt", req_cnt, 0);
    xfer(32'h0314_0004, 32'h0000_0011, 4'b1111, 1'b1, 1, 1, 32'h0);
    chk("nvw_req_cnt", req_cnt, 1);
    chk("nvw_be", f_be, 4'b0001);
    chk("nvw_space", f_space, 3);
    chk("nvw_addr", f_addr, 32'h050001);
    exp_q.push_back(32'h0000_00DD);
    xfer(32'h0314_0008, 32'h0, 4'hF, 1'b0, 2, 2, 32'hAABBCCDD);
    chk("nvr_ack_cyc", ack_cyc, 5);
    chk("err_still_clear", bus_err, 0);

    // End-of-burst strobe starts nothing
    seen_req = 0; seen_ack = 0;
    @(posedge sys_clk); #1;
    wb_adr = 32'h0000_0200; wb_we = 1'b0; wb_cti = 3'b111; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      if (mem_req) seen_req++;
      if (wb_ack) seen_ack++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
    chk("cti_end_req", seen_req, 0);
    chk("cti_end_ack", seen_ack, 0);

    // CPU abandons a read: backend completes, no ack
    seen_ack = 0;
    @(posedge sys_clk); #1;
    wb_adr = 32'h0000_0300; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1; mem_rdata = 32'h77777777;
    @(negedge sys_clk);
    @(posedge sys_clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge sys_clk);
    chk("abort_req_held", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge sys_clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    chk("abort_req_drop", mem_req, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      mem_rvalid = 1'b0;
      if (wb_ack) seen_ack++;
    end
    chk("abort_no_ack", seen_ack, 0);
    exp_q.push_back(32'h0102_0304);
    xfer(32'h0000_0400, 32'h0, 4'hF, 1'b0, 1, 1, 32'h0102_0304);
    chk("post_abort_ack_cyc", ack_cyc, 3);

    // Unmapped read and sticky error
    exp_q.push_back(32'hDEADBEEF);
    xfer(32'h0500_0000, 32'h0, 4'hF, 1'b0, 1, 1, 32'h0);
    chk("unmap_ack_cyc", ack_cyc, 1);
    chk("unmap_req_cnt", req_cnt, 0);
    chk("unmap_err", bus_err, 1);
    exp_q.push_back(32'h3141_5926);
    xfer(32'h0000_0800, 32'h0, 4'hF, 1'b0, 1, 1, 32'h3141_5926);
    chk("err_sticky", bus_err, 1);

    // Reset while waiting for read data
    @(posedge sys_clk); #1;
    wb_adr = 32'h0000_0200; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    mem_gnt = mem_req;
    @(negedge sys_clk);
    mem_gnt = 1'b0;
    reset_n = 1'b0;
    @(negedge sys_clk);
    chk("mid_rst_err", bus_err, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_dat", wb_dat_o, 0);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_ack", wb_ack, 0);
    reset_n = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; mem_rvalid = 1'b1;
    seen_ack = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      mem_rvalid = 1'b0;
      if (wb_ack) seen_ack++;
    end
    chk("stale_rvalid_no_ack", seen_ack, 0);
    exp_q.push_back(32'h2468_ACE0);
    xfer(32'h0000_0104, 32'h0, 4'hF, 1'b0, 1, 1, 32'h2468_ACE0);
    chk("post_rst_ack_cyc", ack_cyc, 3);

`ifdef WBMEM_TIMEOUT_EN
    // Read data never returns: forced completion 16 cycles into RWAIT
    exp_q.push_back(32'hDEADBEEF);
    xfer(32'h0000_0100, 32'h0, 4'hF, 1'b0, 1, 1000, 32'h0);
    chk("tmo_ack_cyc", ack_cyc, 18);
    chk("tmo_err", bus_err, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_mem_bridge.md
Name: wb_mem_bridge

Overview:
- Wishbone slave that sits directly downstream of the ZAP CPU bus in the 3DO core.
- Services every CPU access not claimed by MADAM or CLIO register decode: BIOS ROM, DRAM, VRAM and NVRAM.
- Converts single-beat Classic/registered-burst Wishbone cycles into a req/gnt/rvalid memory-port handshake toward the SDRAM/BRAM backend.
- Owns wb_ack for those regions, plus region classification and error flagging.

Parameters:
- MEM_AW, 22, word-address width of mem_addr (16 MB window).
- TIMEOUT_CYC, 255, cycles to wait for mem_gnt/mem_rvalid before forced completion (WBMEM_TIMEOUT_EN only).
- ERR_DATA, 32'hDEADBEEF, read data returned on unmapped or timed-out reads.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wb_adr  in  32  CPU byte address.
- wb_dat_i  in  32  CPU write data.
- wb_sel  in  4  byte lane enables.
- wb_we  in  1  write strobe.
- wb_cyc  in  1  cycle valid.
- wb_stb  in  1  strobe.
- wb_cti  in  3  cycle type (000 classic, 010 incrementing, 111 end).
- wb_dat_o  out  32  read data to CPU.
- wb_ack  out  1  one-cycle acknowledge.
- mem_req  out  1  backend request, held until mem_gnt.
- mem_we  out  1  backend write.
- mem_space  out  2  region: 0 DRAM, 1 VRAM, 2 ROM, 3 NVRAM.
- mem_addr  out  MEM_AW  backend word address = wb_adr[MEM_AW+1:2].
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  backend accepted the request this cycle.
- mem_rvalid  in  1  read data valid (exactly one pulse per granted read).
- mem_rdata  in  32  read data.
- bus_err  out  1  sticky flag: unmapped access or timeout.

Behaviour:
- Reset: state IDLE. wb_ack, mem_req, mem_we, bus_err = 0; wb_dat_o, mem_addr, mem_wdata = 0; mem_be = 0; mem_space = 0.
- Region decode, applied to wb_adr in IDLE:
  - DRAM 0x00000000–0x001FFFFF
  - VRAM 0x00200000–0x002FFFFF
  - ROM 0x03000000–0x030FFFFF
  - NVRAM 0x03140000–0x0317FFFF
  - anything else is UNMAPPED
- States: IDLE, REQ, RWAIT, ACK.
- IDLE, on wb_cyc & wb_stb:
  - Latch address, data, sel, we and space.
  - Mapped read, or mapped write outside ROM → REQ with mem_req=1 next cycle.
  - ROM write → ACK directly; write is dropped, no mem_req.
  - UNMAPPED → ACK; wb_dat_o=ERR_DATA on reads; bus_err set.
- REQ: mem_req held with all mem_* outputs stable until mem_gnt=1.
  - On gnt, mem_req drops next cycle.
  - Write → ACK; read → RWAIT.
- RWAIT: on mem_rvalid, register mem_rdata into wb_dat_o → ACK.
- ACK: wb_ack=1 for exactly one cycle, then → IDLE. IDLE does not sample wb_stb in the ACK cycle.
- Minimum latencies, counted from first stb cycle (cycle 0):
  - Read with gnt in cycle 1 and rvalid in cycle 2: wb_ack in cycle 3.
  - Write with gnt in cycle 1: wb_ack in cycle 2.
  - ROM write or unmapped: wb_ack in cycle 1.
- NVRAM is byte-wide:
  - Reads return the byte in wb_dat_o[7:0] with upper bits 0.
  - Writes force mem_be=4'b0001 and drop the write entirely if wb_sel[0]=0 (ACK only).
- Bursts: each beat is an independent access using the current wb_adr. cti=111 or wb_stb=0 in IDLE starts nothing.
- wb_cyc dropping mid-transaction:
  - The pending backend transaction completes: mem_req holds until gnt, a read's rvalid is consumed.
  - wb_ack is suppressed; state returns to IDLE.
- mem_rvalid outside RWAIT is ignored.
- bus_err clears only on reset.
- Reset asserted mid-operation: state returns to IDLE and all outputs take their reset values on that edge. Backend outstanding data is discarded.

Optional Feature:
- Macro: WBMEM_TIMEOUT_EN.
- With the macro defined:
  - An 8+ bit counter runs in REQ and RWAIT and clears on entering either state.
  - On reaching TIMEOUT_CYC it forces ACK: mem_req dropped, reads return ERR_DATA, bus_err set.
  - A late mem_rvalid is ignored.
- Without the macro: no counter; REQ and RWAIT wait indefinitely.

Test Plan:
- DRAM read 0x00000100, gnt cycle 1, rvalid cycle 2 with data 0x12345678 → mem_addr=0x40, mem_space=0, wb_ack cycle 3, wb_dat_o=0x12345678.
- VRAM write 0x00200004, data 0xCAFEBABE, sel 4'b0011, gnt held off 3 cycles → mem_req stable for 4 cycles, mem_be=0011, mem_space=1, single wb_ack one cycle after gnt.
- ROM write 0x03000000 → wb_ack cycle 1, mem_req never asserted. Read 0x03000010 → mem_space=2.
- Unmapped read 0x05000000 → wb_ack cycle 1, wb_dat_o=0xDEADBEEF, bus_err=1 and stays 1 after later good accesses.
- NVRAM write 0x03140003, sel 4'b1000 → ack, no mem_req. NVRAM read with mem_rdata 0xAABBCCDD → wb_dat_o=0x000000DD.
- WBMEM_TIMEOUT_EN with TIMEOUT_CYC=16: DRAM read, gnt given, rvalid never comes → wb_ack 16 cycles after entering RWAIT, data ERR_DATA, bus_err=1. Also: reset_n low in RWAIT → next cycle IDLE, all outputs at reset values.
